alu_share_arb: RTL and testbench
================================

# alu_share_arb

Two-port arbiter and sequencer that shares the single 32-bit combinational ALU (ADD/SUB/AND/ORR, NZCV flags) between two requesters, e.g. the execute stage and a debug/test master. Accepts operations via valid/ready, grants round-robin, and drives the ALU from registered operands. Returns each result through a one-entry per-port response buffer. Keeps one architectural NZCV flag register per port, updated under a per-request FlagW mask.

## Interface
- RR_INIT, 1'b1: value of the last-served pointer after reset (1 means port 0 wins the first tie).
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req0_valid / req1_valid  input  1  request present
- req0_ready / req1_ready  output  1  request accepted this cycle
- req0_op / req1_op  input  2  ALU op: 00=ADD, 01=SUB, 10=AND, 11=ORR
- req0_a, req0_b / req1_a, req1_b  input  32  operands
- req0_flagw / req1_flagw  input  2  [1] writes N,Z; [0] writes C,V
- rsp0_valid / rsp1_valid  output  1  result available
- rsp0_ready / rsp1_ready  input  1  result consumed
- rsp0_result / rsp1_result  output  32  result
- flags0 / flags1  output  4  per-port flag register {N,Z,C,V}
- alu_a, alu_b  output  32  to ALU A, B
- alu_ctrl  output  2  to ALU ALUControl
- alu_result  input  32  from ALU Result
- alu_flags  input  4  from ALU ALUFlags {N,Z,C,V}

## Operation
- FSM states: IDLE, EXEC.
- IDLE:
  - Port p is eligible when reqp_valid=1 and rspp_valid=0.
  - One eligible port: grant it.
  - Both eligible: grant the port not equal to the last-served pointer.
  - reqp_ready=1 only for the granted port, combinationally in IDLE; it depends on reqp_valid.
  - On handshake: latch op/A/B into alu_ctrl/alu_a/alu_b registers, latch flagw and the port id, set last-served pointer to p, go to EXEC.
- EXEC:
  - The ALU evaluates the registered operands.
  - At the clock edge: alu_result goes into rspp_result and rspp_valid is set.
  - flagsp[3:2] <= alu_flags[3:2] if flagw[1]; flagsp[1:0] <= alu_flags[1:0] if flagw[0].
  - Return to IDLE.
  - req ready outputs are 0 in EXEC.
- Response buffer: rspp_valid clears on the cycle rspp_valid & rspp_ready is high. While rspp_valid=1, port p is not granted, even if rspp_ready is high that cycle.
- alu_a, alu_b and alu_ctrl hold their last values between operations.
- Flags of one port are never modified by the other port's operations.
- The block applies no arithmetic of its own; width is 32 bits throughout. C/V for AND/ORR come from the ALU as 0.

## Timing
- Reset values:
  - state=IDLE.
  - All ready and rsp_valid outputs 0.
  - rsp results 0, flags0=flags1=4'b0000.
  - alu_a=alu_b=0, alu_ctrl=2'b00.
  - Last-served pointer = RR_INIT.
- Latency: handshake in cycle t → ALU driven in t+1 → rspp_valid=1 in t+2.
- Peak throughput is one operation per 2 cycles, total across both ports.
- A port whose response is consumed in cycle t (rsp_valid & rsp_ready) becomes eligible in cycle t+1.
- Reset asserted in any state, including EXEC, wins over all other events:
  - The in-flight operation is dropped.
  - No response is produced.
  - Flags are cleared.
- Requests not yet accepted may change or drop freely. The block samples them only on handshake.

## Test plan
- After reset: flags0=0, rsp0_valid=0, alu_ctrl=00. Port 0 ADD A=32'hFFFFFFFF B=1, flagw=11 → rsp0_result=0 at t+2; flags0=4'b0110 (Z=1, C=1).
- Port 1 SUB A=5 B=7, flagw=10 → rsp1_result=32'hFFFFFFFE; flags1=4'b1000 (N set; C,V not written, stay 0); flags0 unchanged.
- Both valid every cycle, responses consumed immediately, RR_INIT=1 → grants alternate 0,1,0,1.
- Port 0 ADD 32'h7FFFFFFF+1, flagw=01 → result 32'h80000000; flags0[1:0]=01 (V set), N,Z unchanged.
- Backpressure: rsp0_ready=0 with rsp0_valid=1 and port 0 requesting again → req0_ready stays 0 while port 1 keeps being served. rsp0_ready=1 for one cycle → port 0 granted the next cycle.
- Reset asserted in EXEC of a port 1 ORR → no rsp1_valid afterward; flags1=0; next accepted request completes normally.

Source files
------------

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin sharing of one external ALU between two requesters
module alu_share_arb #(
    parameter logic RR_INIT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [1:0]  req0_flagw,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [1:0]  req1_flagw,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic [3:0]  flags0,
    output logic [3:0]  flags1,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [1:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t     state;
    logic       last_served;
    logic       cur_port;
    logic [1:0] cur_flagw;

    logic       elig0;
    logic       elig1;
    logic       grant_any;
    logic       grant_port;

    // Eligibility and round-robin pick; a port with an unconsumed response is held off
    always_comb begin
        elig0     = req0_valid & ~rsp0_valid;
        elig1     = req1_valid & ~rsp1_valid;
        grant_any = elig0 | elig1;
        if (elig0 & elig1) begin
            grant_port = ~last_served;
        end else begin
            grant_port = elig1;
        end
        req0_ready = (state == IDLE) & elig0 & ~grant_port;
        req1_ready = (state == IDLE) & elig1 & grant_port;
    end

    // Sequencer: latch the granted operation, then capture the ALU output one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_served <= RR_INIT;
            cur_port    <= 1'b0;
            cur_flagw   <= 2'b00;
            alu_a       <= 32'd0;
            alu_b       <= 32'd0;
            alu_ctrl    <= 2'b00;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp0_result <= 32'd0;
            rsp1_result <= 32'd0;
            flags0      <= 4'b0000;
            flags1      <= 4'b0000;
        end else begin
            if (rsp0_valid & rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end
            if (rsp1_valid & rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        alu_ctrl    <= grant_port ? req1_op    : req0_op;
                        alu_a       <= grant_port ? req1_a     : req0_a;
                        alu_b       <= grant_port ? req1_b     : req0_b;
                        cur_flagw   <= grant_port ? req1_flagw : req0_flagw;
                        cur_port    <= grant_port;
                        last_served <= grant_port;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    // The granted port had no pending response, so setting valid here never races the clear above
                    if (cur_port == 1'b0) begin
                        rsp0_result <= alu_result;
                        rsp0_valid  <= 1'b1;
                        if (cur_flagw[1]) begin
                            flags0[3:2] <= alu_flags[3:2];
                        end
                        if (cur_flagw[0]) begin
                            flags0[1:0] <= alu_flags[1:0];
                        end
                    end else begin
                        rsp1_result <= alu_result;
                        rsp1_valid  <= 1'b1;
                        if (cur_flagw[1]) begin
                            flags1[3:2] <= alu_flags[3:2];
                        end
                        if (cur_flagw[0]) begin
                            flags1[1:0] <= alu_flags[1:0];
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - randomized scoreboard bench for alu_share_arb
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]  req0_flagw = '0, req1_flagw = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] rsp0_result, rsp1_result;
    logic [3:0]  flags0, flags1;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [1:0]  alu_ctrl;
    logic [3:0]  alu_flags;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_arb #(.RR_INIT(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_flagw(req0_flagw),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_flagw(req1_flagw),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .flags0(flags0), .flags1(flags1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags)
    );

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [3:0] ref_flg(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic c, v;
        r = ref_res(op, a, b);
        c = 1'b0;
        v = 1'b0;
        if (op == 2'd0) begin
            c = (({1'b0, a} + {1'b0, b}) > 33'h0FFFFFFFF);
            v = (a[31] == b[31]) && (r[31] != a[31]);
        end else if (op == 2'd1) begin
            c = (a >= b);
            v = (a[31] != b[31]) && (r[31] != a[31]);
        end
        return {r[31], (r == 32'd0), c, v};
    endfunction

    // external ALU stand-in
    assign alu_result = ref_res(alu_ctrl, alu_a, alu_b);
    assign alu_flags  = ref_flg(alu_ctrl, alu_a, alu_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    // reference model state, tracked per clock cycle
    logic            m_busy = 1'b0;
    logic            m_last = 1'b1;
    logic            m_port = 1'b0;
    logic [1:0]      m_rspv = 2'b00;
    logic [1:0][3:0] m_flags = '0;
    logic [3:0]      m_nf = '0;
    logic [31:0]     m_a = '0, m_b = '0;
    logic [1:0]      m_op = '0;

    always @(negedge clk) begin : model
        logic [1:0]  el, gr, rdy;
        logic        gp;
        logic [1:0]  op, fw;
        logic [31:0] a, b;
        logic [3:0]  af, nf;
        exp_t        e;
        el  = {req1_valid & ~m_rspv[1], req0_valid & ~m_rspv[0]};
        gr  = 2'b00;
        gp  = (el == 2'b11) ? ~m_last : el[1];
        if (!m_busy && el != 2'b00) gr[gp] = 1'b1;
        check("req0_ready", req0_ready, gr[0]);
        check("req1_ready", req1_ready, gr[1]);
        check("rsp0_valid", rsp0_valid, m_rspv[0]);
        check("rsp1_valid", rsp1_valid, m_rspv[1]);
        check("flags0", flags0, m_flags[0]);
        check("flags1", flags1, m_flags[1]);
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_ctrl", alu_ctrl, m_op);
        if (reset) begin
            m_busy  = 1'b0;
            m_last  = 1'b1;
            m_rspv  = 2'b00;
            m_flags = '0;
            m_a     = '0;
            m_b     = '0;
            m_op    = '0;
            q0.delete();
            q1.delete();
        end else begin
            rdy = {rsp1_ready, rsp0_ready};
            m_rspv = m_rspv & ~rdy;
            if (m_busy) begin
                m_rspv[m_port]  = 1'b1;
                m_flags[m_port] = m_nf;
                m_busy = 1'b0;
            end else if (gr != 2'b00) begin
                op = gp ? req1_op : req0_op;
                a  = gp ? req1_a : req0_a;
                b  = gp ? req1_b : req0_b;
                fw = gp ? req1_flagw : req0_flagw;
                af = ref_flg(op, a, b);
                nf = m_flags[gp];
                if (fw[1]) nf[3:2] = af[3:2];
                if (fw[0]) nf[1:0] = af[1:0];
                m_nf   = nf;
                m_busy = 1'b1;
                m_last = gp;
                m_port = gp;
                m_op   = op;
                m_a    = a;
                m_b    = b;
                e.res  = ref_res(op, a, b);
                e.flg  = nf;
                if (gp) q1.push_back(e);
                else    q0.push_back(e);
            end
        end
    end

    // response monitor: pops the scoreboard whenever a response is consumed
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rsp0_unexpected: got response %h expected none", rsp0_result);
                end else begin
                    e = q0.pop_front();
                    check("rsp0_result", rsp0_result, e.res);
                    check("rsp0_flags", flags0, e.flg);
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rsp1_unexpected: got response %h expected none", rsp1_result);
                end else begin
                    e = q1.pop_front();
                    check("rsp1_result", rsp1_result, e.res);
                    check("rsp1_flags", flags1, e.flg);
                end
            end
        end
    end

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h7FFFFFFF;
            3:       return 32'h80000000;
            default: return $urandom();
        endcase
    endfunction

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic rand_ops();
        req0_op = 2'($urandom_range(0, 3)); req0_a = rnd32(); req0_b = rnd32(); req0_flagw = 2'($urandom_range(0, 3));
        req1_op = 2'($urandom_range(0, 3)); req1_a = rnd32(); req1_b = rnd32(); req1_flagw = 2'($urandom_range(0, 3));
    endtask

    task automatic issue(input int p, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [1:0] fw);
        int n;
        logic got;
        if (p == 0) begin
            req0_op = op; req0_a = a; req0_b = b; req0_flagw = fw; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_a = a; req1_b = b; req1_flagw = fw; req1_valid = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            got = (p == 0) ? req0_ready : req1_ready;
        end while (!got && n < 20);
        check("handshake", got, 1'b1);
        @(posedge clk); #1;
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int p);
        int n;
        logic got;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            got = (p == 0) ? rsp0_valid : rsp1_valid;
        end while (!got && n < 10);
        check("rsp_arrives", got, 1'b1);
    endtask

    task automatic consume(input int p);
        @(posedge clk); #1;
        if (p == 0) rsp0_ready = 1'b1;
        else        rsp1_ready = 1'b1;
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    initial begin : stim
        int gs[$];
        int n1, k;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_flags0", flags0, 4'b0000);
        check("rst_rsp0_valid", rsp0_valid, 1'b0);
        check("rst_alu_ctrl", alu_ctrl, 2'b00);
        check("rst_alu_a", alu_a, 32'd0);
        @(posedge clk); #1;

        issue(0, 2'd0, 32'hFFFFFFFF, 32'd1, 2'b11);
        wait_rsp(0);
        check("add_wrap_result", rsp0_result, 32'h0);
        check("add_wrap_flags", flags0, 4'b0110);
        consume(0);

        issue(1, 2'd1, 32'd5, 32'd7, 2'b10);
        wait_rsp(1);
        check("sub_result", rsp1_result, 32'hFFFFFFFE);
        check("sub_flags1", flags1, 4'b1000);
        check("sub_flags0_kept", flags0, 4'b0110);
        consume(1);

        issue(0, 2'd0, 32'h7FFFFFFF, 32'd1, 2'b01);
        wait_rsp(0);
        check("ovf_result", rsp0_result, 32'h80000000);
        check("ovf_flags", flags0, 4'b0101);
        consume(0);

        issue(1, 2'd3, 32'hF0F0F0F0, 32'h0000000F, 2'b11);
        pulse_reset();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("drop_rsp1_valid", rsp1_valid, 1'b0);
        check("drop_flags1", flags1, 4'b0000);
        @(posedge clk); #1;
        issue(1, 2'd0, 32'd3, 32'd4, 2'b11);
        wait_rsp(1);
        check("post_reset_result", rsp1_result, 32'd7);
        consume(1);

        pulse_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            @(negedge clk);
            if (req0_valid && req0_ready) gs.push_back(0);
            if (req1_valid && req1_ready) gs.push_back(1);
            @(posedge clk); #1;
        end
        check("alt_count", 32'(gs.size() >= 6), 1);
        for (int i = 0; i < 6 && i < gs.size(); i++) check("alt_grant", gs[i], i % 2);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        issue(0, 2'd0, 32'd10, 32'd20, 2'b11);
        wait_rsp(0);
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        n1 = 0;
        for (int i = 0; i < 10; i++) begin
            rand_ops();
            @(negedge clk);
            check("bp_req0_ready", req0_ready, 1'b0);
            if (req1_ready) n1++;
            @(posedge clk); #1;
        end
        check("bp_port1_served", 32'(n1 >= 4), 1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!req1_ready && k < 10);
        check("bp_port1_handshake", req1_ready, 1'b1);
        @(posedge clk); #1 rsp0_ready = 1'b1;
        @(posedge clk); #1 rsp0_ready = 1'b0;
        @(negedge clk);
        check("bp_regrant", req0_ready, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;

        for (int i = 0; i < 1500; i++) begin
            rand_ops();
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            rsp0_ready = ($urandom_range(0, 4) < 3);
            rsp1_ready = ($urandom_range(0, 4) < 3);
            reset = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("drained", q0.size() + q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
